// File: rtl/mips_pkg.sv
// Shared definitions for the mini MIPS datapath: widths, special encodings and the
// IF/ID pipeline register layout reused by decode.
package mips_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 16'h0000;
  localparam logic [INSTR_W-1:0] HALT_INSTR    = 16'hFFFF;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               valid;
  } if_id_t;

  // Word addressing, so the sequential successor is +1 and simply wraps.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/mips_pc_next.sv
// Combinational next-PC select: jump beats branch beats sequential increment.
// Redirects only count when the instruction in IF/ID is valid.
module mips_pc_next
  import mips_pkg::*;
#(
  parameter int unsigned BR_OFF_W = 6,
  parameter int unsigned JMP_W    = 12
) (
  input  logic [ADDR_W-1:0]   pc,
  input  logic [ADDR_W-1:0]   if_id_pc,
  input  logic                if_id_valid,
  input  logic                branch_taken,
  input  logic [BR_OFF_W-1:0] branch_offset,
  input  logic                jump_en,
  input  logic [JMP_W-1:0]    jump_target,
  output logic [ADDR_W-1:0]   next_pc,
  output logic                redirect
);

  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;
  logic              take_jump;
  logic              take_branch;

  always_comb begin
    br_tgt      = if_id_pc + {{(ADDR_W-BR_OFF_W){branch_offset[BR_OFF_W-1]}}, branch_offset};
    jmp_tgt     = {if_id_pc[ADDR_W-1:JMP_W], jump_target};
    take_jump   = if_id_valid & jump_en;
    take_branch = if_id_valid & branch_taken;
    redirect    = take_jump | take_branch;
    if (take_jump) begin
      next_pc = jmp_tgt;
    end else if (take_branch) begin
      next_pc = br_tgt;
    end else begin
      next_pc = pc_incr(pc);
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// fills IF/ID. Define MIPS_FETCH_HALT_EN to stop fetch when 16'hFFFF reaches IF/ID.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
  parameter int unsigned        BR_OFF_W  = 6,
  parameter int unsigned        JMP_W     = 12,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [BR_OFF_W-1:0] branch_offset,
  input  logic                jump_en,
  input  logic [JMP_W-1:0]    jump_target,
  input  logic [INSTR_W-1:0]  instr_mem_data,
  output logic [ADDR_W-1:0]   instr_mem_addr,
  output logic [INSTR_W-1:0]  if_id_instr,
  output logic [ADDR_W-1:0]   if_id_pc,
  output logic                if_id_valid,
  output logic                halted
);

  logic [ADDR_W-1:0] pc_q;
  if_id_t            if_id_q;
  logic [ADDR_W-1:0] next_pc;
  logic              redirect;
  logic              freeze;

  mips_pc_next #(
    .BR_OFF_W (BR_OFF_W),
    .JMP_W    (JMP_W)
  ) u_pc_next (
    .pc            (pc_q),
    .if_id_pc      (if_id_q.pc),
    .if_id_valid   (if_id_q.valid),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

`ifdef MIPS_FETCH_HALT_EN
  logic halted_q;
  logic halt_hit;

  assign halt_hit = if_id_q.valid && (if_id_q.instr == HALT_INSTR);
  // The edge that sees the halt word already freezes everything.
  assign freeze   = halted_q | halt_hit;
  assign halted   = halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (halt_hit) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign freeze = 1'b0;
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_q.instr <= NOP_INSTR;
      if_id_q.pc    <= '0;
      if_id_q.valid <= 1'b0;
    end else if (!freeze) begin
      if (redirect) begin
        // Flush the wrong-path word; if_id_pc is left as is.
        pc_q          <= next_pc;
        if_id_q.instr <= NOP_INSTR;
        if_id_q.valid <= 1'b0;
      end else if (!stall) begin
        pc_q          <= next_pc;
        if_id_q.instr <= instr_mem_data;
        if_id_q.pc    <= next_pc;
        if_id_q.valid <= 1'b1;
      end
    end
  end

  assign instr_mem_addr = pc_q;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios plus random stimulus,
// all compared against a cycle-level reference model of the fetch rules.
module tb_mips_fetch_unit;

`ifdef MIPS_FETCH_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [5:0]  branch_offset;
  logic        jump_en;
  logic [11:0] jump_target;
  logic [15:0] instr_mem_data;
  logic [31:0] instr_mem_addr;
  logic [15:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;

  logic [15:0] mem [256];
  assign instr_mem_data = mem[instr_mem_addr[7:0]];

  always #5 clk = ~clk;

  mips_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump_en        (jump_en),
    .jump_target    (jump_target),
    .instr_mem_data (instr_mem_data),
    .instr_mem_addr (instr_mem_addr),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [31:0] m_pc;
  logic [15:0] m_instr;
  logic [31:0] m_ifpc;
  logic        m_valid;
  logic        m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("addr", instr_mem_addr, m_pc);
    check("if_id_instr", 32'(if_id_instr), 32'(m_instr));
    check("if_id_pc", if_id_pc, m_ifpc);
    check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    check("halted", 32'(halted), 32'(m_halted));
  endtask

  // One clock: drive inputs, advance the model by the fetch rules, compare after the edge.
  task automatic step(input logic r, input logic s, input logic b, input logic [5:0] o,
                      input logic j, input logic [11:0] t);
    logic [31:0] n_pc, n_ifpc;
    logic [15:0] n_instr;
    logic        n_valid, n_halted;
    rst = r; stall = s; branch_taken = b; branch_offset = o; jump_en = j; jump_target = t;
    n_pc = m_pc; n_ifpc = m_ifpc; n_instr = m_instr; n_valid = m_valid; n_halted = m_halted;
    if (r) begin
      n_pc = 32'h0; n_instr = 16'h0; n_ifpc = 32'h0; n_valid = 1'b0; n_halted = 1'b0;
    end else if (m_halted) begin
      // frozen
    end else if (HaltEn && m_valid && m_instr == 16'hFFFF) begin
      n_halted = 1'b1;
    end else if (m_valid && (j || b)) begin
      if (j) n_pc = {m_ifpc[31:12], t};
      else   n_pc = m_ifpc + 32'(signed'(o));
      n_instr = 16'h0;
      n_valid = 1'b0;
    end else if (!s) begin
      n_instr = mem[m_pc[7:0]];
      n_pc    = m_pc + 32'd1;
      n_ifpc  = m_pc + 32'd1;
      n_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ifpc = n_ifpc; m_instr = n_instr; m_valid = n_valid; m_halted = n_halted;
    check_all();
  endtask

  task automatic run_normal(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 12'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 12'd0);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'hFFFF) w = 16'hFFFE;
    return w;
  endfunction

  initial begin
    int guard;
    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    jump_en = 1'b0; jump_target = '0;
    m_pc = '0; m_ifpc = '0; m_instr = '0; m_valid = 1'b0; m_halted = 1'b0;

    // Reset values
    do_reset();
    do_reset();
    check("rst_addr", instr_mem_addr, 32'h0);
    check("rst_valid", 32'(if_id_valid), 32'h0);
    check("rst_instr", 32'(if_id_instr), 32'h0);

    // Free run
    run_normal(1);
    check("run1_addr", instr_mem_addr, 32'd1);
    check("run1_instr", 32'(if_id_instr), 32'h1111);
    check("run1_pc", if_id_pc, 32'd1);
    check("run1_valid", 32'(if_id_valid), 32'd1);
    run_normal(2);
    check("run3_addr", instr_mem_addr, 32'd3);
    check("run3_instr", 32'(if_id_instr), 32'h3333);
    check("run3_pc", if_id_pc, 32'd3);

    // Stall two cycles at pc 5
    run_normal(2);
    step(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 12'd0);
    step(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 12'd0);
    check("stall_addr", instr_mem_addr, 32'd5);
    check("stall_pc", if_id_pc, 32'd5);
    run_normal(1);
    check("unstall_addr", instr_mem_addr, 32'd6);

    // Branch back by 4 from if_id_pc 8, then an unqualified branch is ignored
    run_normal(2);
    check("pre_br_ifpc", if_id_pc, 32'd8);
    step(1'b0, 1'b0, 1'b1, 6'b111100, 1'b0, 12'd0);
    check("br_addr", instr_mem_addr, 32'd4);
    check("br_valid", 32'(if_id_valid), 32'd0);
    check("br_instr", 32'(if_id_instr), 32'h0);
    step(1'b0, 1'b0, 1'b1, 6'b111100, 1'b0, 12'd0);
    check("br_bubble_ignored", instr_mem_addr, 32'd5);

    // Wrap: branch to 0xFFFFFFFF, then sequential fetch rolls to 0
    do_reset();
    run_normal(1);
    step(1'b0, 1'b0, 1'b1, 6'b111110, 1'b0, 12'd0);
    check("wrap_top", instr_mem_addr, 32'hFFFF_FFFF);
    run_normal(1);
    check("wrap_addr", instr_mem_addr, 32'h0);
    check("wrap_ifpc", if_id_pc, 32'h0);

    // Jump page test: get if_id_pc to 0x3005
    do_reset();
    run_normal(1);
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 12'hFFF);
    check("jmp_fff", instr_mem_addr, 32'h0000_0FFF);
    guard = 0;
    while (m_pc != 32'h0000_3005 && guard < 20000) begin
      run_normal(1);
      guard++;
    end
    if (guard >= 20000) check("run_to_3005_bound", 32'd0, 32'd1);
    check("pre_jmp_ifpc", if_id_pc, 32'h0000_3005);
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 12'hABC);
    check("jmp_addr", instr_mem_addr, 32'h0000_3ABC);
    run_normal(1);
    step(1'b0, 1'b1, 1'b1, 6'b000101, 1'b1, 12'hABC);
    check("jmp_prio_addr", instr_mem_addr, 32'h0000_3ABC);
    check("jmp_prio_valid", 32'(if_id_valid), 32'd0);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), 6'($urandom), ($urandom_range(0, 4) == 0),
           12'($urandom));
    end

    // Halt word at address 3
    mem[3] = 16'hFFFF;
    do_reset();
    run_normal(5);
    if (HaltEn) begin
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_addr", instr_mem_addr, 32'd4);
      step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 12'h123);
      step(1'b0, 1'b0, 1'b1, 6'b000011, 1'b0, 12'd0);
      check("halt_ignore_redirect", instr_mem_addr, 32'd4);
      check("halt_sticky", 32'(halted), 32'd1);
      do_reset();
      check("halt_rst_flag", 32'(halted), 32'd0);
      check("halt_rst_addr", instr_mem_addr, 32'd0);
    end else begin
      check("nohalt_flag", 32'(halted), 32'd0);
      check("nohalt_addr", instr_mem_addr, 32'd5);
      run_normal(1);
      check("nohalt_addr2", instr_mem_addr, 32'd6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
